// File: rtl/enable_sequencer_if.sv
// enable_sequencer_if
//   Bundles the configuration, request and status signals of the enable
//   sequencer. Clock and reset stay outside as plain ports.
//   master : drives cfg_we/cfg_idx/cfg_delay/start/stop, observes status
//   slave  : the sequencer itself
//   cfg_we, cfg_idx, cfg_delay : delay register write port
//   start, stop                : level-sampled sequence requests
//   en_out                     : registered stage enables
//   busy, all_on, done         : registered status (done is a 1-cycle pulse)
interface enable_sequencer_if #(
   parameter int NUM_STAGES = 4,
   parameter int CNT_W      = 16,
   parameter int IDX_W      = 2
);
   logic                  cfg_we;
   logic [IDX_W-1:0]      cfg_idx;
   logic [CNT_W-1:0]      cfg_delay;
   logic                  start;
   logic                  stop;
   logic [NUM_STAGES-1:0] en_out;
   logic                  busy;
   logic                  all_on;
   logic                  done;

   modport master (
      output cfg_we, cfg_idx, cfg_delay, start, stop,
      input  en_out, busy, all_on, done
   );

   modport slave (
      input  cfg_we, cfg_idx, cfg_delay, start, stop,
      output en_out, busy, all_on, done
   );
endinterface

// File: rtl/enable_sequencer.sv
// enable_sequencer
//   Raises NUM_STAGES enables one after another on start, each after its own
//   programmable delay, and lowers them in reverse order on stop. A stop
//   during power-up aborts it and unwinds only the stages already enabled.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (drops all enables immediately)
//   bus   : enable_sequencer_if.slave (config port, start/stop, status)
module enable_sequencer #(
   parameter int NUM_STAGES    = 4,
   parameter int CNT_W         = 16,
   parameter int IDX_W         = 2,
   parameter int DEFAULT_DELAY = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   enable_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, UP, ON, DOWN} state_t;

   state_t                state_reg, state_next;
   logic [IDX_W-1:0]      s_reg, s_next;
   logic [CNT_W-1:0]      cnt_reg, cnt_next;
   logic [NUM_STAGES-1:0] en_reg, en_next;
   logic                  busy_reg, busy_next;
   logic                  all_on_reg, all_on_next;
   logic                  done_reg, done_next;

   logic [CNT_W-1:0]      dly_reg [NUM_STAGES];
   logic [NUM_STAGES-1:0] dly_we;
   logic [NUM_STAGES-1:0] stage_sel;
   logic [CNT_W-1:0]      dly_cur;
   logic                  wr_en;
   logic                  matured;
   logic                  s_is_first;
   logic                  s_is_last;

   // Writes are accepted only while idle; an index with no matching stage
   // decodes to no write enable and is dropped.
   assign wr_en = bus.cfg_we && (state_reg == IDLE);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
         assign dly_we[gi]    = wr_en && (bus.cfg_idx == IDX_W'(gi));
         assign stage_sel[gi] = (s_reg == IDX_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            dly_reg[i] <= CNT_W'(DEFAULT_DELAY);
         end
      end else begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            if (dly_we[i]) begin
               dly_reg[i] <= bus.cfg_delay;
            end
         end
      end
   end

   // Delay of the stage currently being timed, selected by the one-hot decode.
   always_comb begin
      dly_cur = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (stage_sel[i]) begin
            dly_cur = dly_reg[i];
         end
      end
   end

   assign matured    = (cnt_reg == dly_cur);
   assign s_is_first = (s_reg == '0);
   assign s_is_last  = (s_reg == IDX_W'(NUM_STAGES - 1));

   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      cnt_next   = cnt_reg;
      en_next    = en_reg;
      done_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            // stop has priority over a simultaneous start
            if (!bus.stop && bus.start) begin
               state_next = UP;
               s_next     = '0;
               cnt_next   = '0;
            end
         end
         UP: begin
            if (bus.stop) begin
               // Abort: the stage being timed is never enabled, even if its
               // count matures on this edge.
               cnt_next = '0;
               if (s_is_first) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  state_next = DOWN;
                  s_next     = s_reg - IDX_W'(1);
               end
            end else if (matured) begin
               en_next  = en_reg | stage_sel;
               cnt_next = '0;
               if (s_is_last) begin
                  state_next = ON;
               end else begin
                  s_next = s_reg + IDX_W'(1);
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         ON: begin
            en_next = '1;
            if (bus.stop) begin
               state_next = DOWN;
               s_next     = IDX_W'(NUM_STAGES - 1);
               cnt_next   = '0;
            end
         end
         DOWN: begin
            if (matured) begin
               en_next  = en_reg & ~stage_sel;
               cnt_next = '0;
               if (s_is_first) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  s_next = s_reg - IDX_W'(1);
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            en_next    = '0;
         end
      endcase

      // Status flags are registered from the next state so they line up
      // with the state they describe.
      busy_next   = (state_next == UP) || (state_next == DOWN);
      all_on_next = (state_next == ON);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         s_reg      <= '0;
         cnt_reg    <= '0;
         en_reg     <= '0;
         busy_reg   <= 1'b0;
         all_on_reg <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         s_reg      <= s_next;
         cnt_reg    <= cnt_next;
         en_reg     <= en_next;
         busy_reg   <= busy_next;
         all_on_reg <= all_on_next;
         done_reg   <= done_next;
      end
   end

   assign bus.en_out = en_reg;
   assign bus.busy   = busy_reg;
   assign bus.all_on = all_on_reg;
   assign bus.done   = done_reg;

endmodule

// File: tb/tb_enable_sequencer.sv
// tb_enable_sequencer
//   Directed bench for enable_sequencer. Expected output events (enable
//   changes and done pulses) are queued when a request is driven and popped
//   as the design produces them. cfg_idx is one bit wider than needed so
//   that out-of-range stage indices can be written.
module tb_enable_sequencer;

   localparam int NS  = 4;
   localparam int CW  = 16;
   localparam int IW  = 3;

   typedef struct {
      int         cyc;
      logic [3:0] en;
      logic       busy;
      logic       all_on;
      logic       done;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   logic [3:0] prev_en;

   always #5 clk = ~clk;

   enable_sequencer_if #(.NUM_STAGES(NS), .CNT_W(CW), .IDX_W(IW)) bus ();

   enable_sequencer #(
      .NUM_STAGES(NS), .CNT_W(CW), .IDX_W(IW), .DEFAULT_DELAY(10)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int cyc, input logic [3:0] en, input logic b,
                       input logic a, input logic d);
      exp_t e;
      e.cyc = cyc; e.en = en; e.busy = b; e.all_on = a; e.done = d;
      sb.push_back(e);
   endtask

   // Drive a request for exactly one sampling edge, then check the state
   // reached on that edge.
   task automatic go(input logic st, input logic sp, input logic eb,
                     input logic ed, input logic [3:0] een, input string tag);
      bus.start = st;
      bus.stop  = sp;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.stop   = 1'b0;
      bus.cfg_we = 1'b0;
      check({tag, "_busy"}, 32'(bus.busy), 32'(eb));
      check({tag, "_done"}, 32'(bus.done), 32'(ed));
      check({tag, "_en"},   32'(bus.en_out), 32'(een));
      prev_en = een;
   endtask

   task automatic wr(input int idx, input int val);
      bus.cfg_we    = 1'b1;
      bus.cfg_idx   = IW'(idx);
      bus.cfg_delay = CW'(val);
      @(posedge clk);
      #1;
      bus.cfg_we = 1'b0;
   endtask

   // Count edges from the request edge; every output event pops one entry.
   task automatic watch(input int budget, input string tag);
      int   k = 0;
      exp_t e;
      while (sb.size() > 0 && k < budget) begin
         @(posedge clk);
         k++;
         #1;
         if (bus.en_out !== prev_en || bus.done !== 1'b0) begin
            e = sb.pop_front();
            check({tag, "_cyc"},    32'(k),          32'(e.cyc));
            check({tag, "_en"},     32'(bus.en_out), 32'(e.en));
            check({tag, "_busy"},   32'(bus.busy),   32'(e.busy));
            check({tag, "_all_on"}, 32'(bus.all_on), 32'(e.all_on));
            check({tag, "_done"},   32'(bus.done),   32'(e.done));
            prev_en = e.en;
         end
      end
      if (sb.size() > 0) begin
         check({tag, "_timeout"}, 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   task automatic quiet(input int n, input string tag);
      logic moved = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (bus.en_out !== prev_en || bus.done !== 1'b0) moved = 1'b1;
      end
      check({tag, "_quiet"}, 32'(moved), 32'd0);
   endtask

   task automatic push_default_up();
      push(11, 4'b0001, 1'b1, 1'b0, 1'b0);
      push(22, 4'b0011, 1'b1, 1'b0, 1'b0);
      push(33, 4'b0111, 1'b1, 1'b0, 1'b0);
      push(44, 4'b1111, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic push_prog_up();
      push(1,  4'b0001, 1'b1, 1'b0, 1'b0);
      push(5,  4'b0011, 1'b1, 1'b0, 1'b0);
      push(7,  4'b0111, 1'b1, 1'b0, 1'b0);
      push(13, 4'b1111, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic push_prog_down();
      push(6,  4'b0111, 1'b1, 1'b0, 1'b0);
      push(8,  4'b0011, 1'b1, 1'b0, 1'b0);
      push(12, 4'b0001, 1'b1, 1'b0, 1'b0);
      push(13, 4'b0000, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.cfg_we    = 1'b0;
      bus.cfg_idx   = '0;
      bus.cfg_delay = '0;
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      prev_en       = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      check("rst_en",     32'(bus.en_out), 32'd0);
      check("rst_busy",   32'(bus.busy),   32'd0);
      check("rst_all_on", 32'(bus.all_on), 32'd0);
      check("rst_done",   32'(bus.done),   32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Default power-up, start ignored in ON, start held through DOWN.
      go(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "def_start");
      push_default_up();
      watch(60, "def_up");
      go(1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, "on_start");
      quiet(5, "on_start");
      go(1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, "def_stop");
      push(11, 4'b0111, 1'b1, 1'b0, 1'b0);
      push(22, 4'b0011, 1'b1, 1'b0, 1'b0);
      push(33, 4'b0001, 1'b1, 1'b0, 1'b0);
      push(44, 4'b0000, 1'b0, 1'b0, 1'b1);
      bus.start = 1'b1;
      watch(60, "def_down");
      bus.start = 1'b0;
      quiet(5, "def_idle");

      // Reprogram {0,3,1,5}; the stage-3 write shares the start edge.
      wr(0, 0);
      wr(1, 3);
      wr(2, 1);
      bus.cfg_we    = 1'b1;
      bus.cfg_idx   = 3'd3;
      bus.cfg_delay = 16'd5;
      go(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "prog_start");
      push_prog_up();
      watch(30, "prog_up");
      go(1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, "prog_stop");
      push_prog_down();
      watch(30, "prog_down");
      quiet(5, "prog_idle");

      // Out-of-range write while idle, in-range write held while busy.
      wr(5, 40);
      go(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "gate_start");
      bus.cfg_we    = 1'b1;
      bus.cfg_idx   = 3'd2;
      bus.cfg_delay = 16'd9;
      push_prog_up();
      watch(30, "gate_up");
      bus.cfg_we = 1'b0;
      go(1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, "gate_stop");
      push_prog_down();
      watch(30, "gate_down");

      // Abort while stage 2 counts: unwind stages 1 and 0 only.
      go(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "abort_start");
      push(1, 4'b0001, 1'b1, 1'b0, 1'b0);
      push(5, 4'b0011, 1'b1, 1'b0, 1'b0);
      watch(30, "abort_up");
      go(1'b0, 1'b1, 1'b1, 1'b0, 4'b0011, "abort_stop");
      push(4, 4'b0001, 1'b1, 1'b0, 1'b0);
      push(5, 4'b0000, 1'b0, 1'b0, 1'b1);
      watch(30, "abort_down");
      quiet(10, "abort_idle");

      // Abort before any stage is enabled.
      go(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "early_start");
      go(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, "early_stop");
      quiet(5, "early_idle");

      // start and stop together in IDLE.
      go(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, "both");
      quiet(20, "both");

      // Asynchronous reset mid-UP, then default timing again.
      go(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "ar_start");
      push(1, 4'b0001, 1'b1, 1'b0, 1'b0);
      watch(10, "ar_up");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("ar_en",     32'(bus.en_out), 32'd0);
      check("ar_busy",   32'(bus.busy),   32'd0);
      check("ar_all_on", 32'(bus.all_on), 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      prev_en = 4'b0000;
      go(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "ar_restart");
      push_default_up();
      watch(60, "ar_def_up");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
